// File: rtl/hardware_ram_responder_if.sv
// CPU <-> RAM responder bus: packed request word in, status word and telemetry out.
interface hardware_ram_responder_if;
    localparam int unsigned REQ_W = 129;
    localparam int unsigned STS_W = 65;
    localparam int unsigned CNT_W = 32;

    logic [REQ_W-1:0] cpureq_i;
    logic [STS_W-1:0] ramstatus_o;
    logic             busy_o;
    logic [CNT_W-1:0] txn_count_o;

    modport master (output cpureq_i, input ramstatus_o, busy_o, txn_count_o);
    modport slave  (input cpureq_i, output ramstatus_o, busy_o, txn_count_o);
endinterface

// File: rtl/hardware_ram_responder.sv
// Single-outstanding RAM responder: accepts one read/write from the CPU request word,
// serves it from a local word array and returns a one-cycle status pulse after LATENCY cycles.
module hardware_ram_responder #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 2
) (
    input  logic                     system1000,
    input  logic                     system1000_rstn,
    hardware_ram_responder_if.slave  bus
);
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned TXN_W  = 32;
    localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_e;

    // Request word fields
    logic              wr_vld_c;
    logic [ADDR_W-1:0] wr_addr_c;
    logic [DATA_W-1:0] wr_data_c;
    logic              rd_vld_c;
    logic [ADDR_W-1:0] rd_addr_c;
    logic              run_c;
    logic              unused_cpureq_c;

    assign wr_vld_c        = bus.cpureq_i[128];
    assign wr_addr_c       = bus.cpureq_i[98 +: ADDR_W];
    assign wr_data_c       = bus.cpureq_i[97:34];
    assign rd_vld_c        = bus.cpureq_i[33];
    assign rd_addr_c       = bus.cpureq_i[1 +: ADDR_W];
    assign run_c           = bus.cpureq_i[0];
    assign unused_cpureq_c = ^bus.cpureq_i;

    logic [DATA_W-1:0] mem_q [DEPTH];

    state_e            state_q,    state_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic [DATA_W-1:0] data_q,     data_d;
    logic              rsp_vld_q,  rsp_vld_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              busy_q,     busy_d;
    logic [TXN_W-1:0]  txn_q,      txn_d;
    logic              mem_we_c;

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        rsp_vld_d  = 1'b0;
        rsp_data_d = rsp_data_q;
        txn_d      = txn_q;
        mem_we_c   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (run_c && (wr_vld_c || rd_vld_c)) begin
                    mem_we_c = wr_vld_c;
                    data_d   = wr_vld_c ? wr_data_c : mem_q[rd_addr_c];
                    if (LATENCY <= 1) begin
                        state_d    = ST_RESP;
                        rsp_vld_d  = 1'b1;
                        rsp_data_d = data_d;
                        txn_d      = txn_q + TXN_W'(1);
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d    = ST_RESP;
                    rsp_vld_d  = 1'b1;
                    rsp_data_d = data_q;
                    txn_d      = txn_q + TXN_W'(1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge system1000) begin
        if (!system1000_rstn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            data_q     <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_data_q <= '0;
            busy_q     <= 1'b0;
            txn_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_data_q <= rsp_data_d;
            busy_q     <= busy_d;
            txn_q      <= txn_d;
        end
    end

    // Word array is never reset; writes land on the accepting edge
    always_ff @(posedge system1000) begin
        if (system1000_rstn && mem_we_c) begin
            mem_q[wr_addr_c] <= wr_data_c;
        end
    end

    assign bus.ramstatus_o = {rsp_vld_q, rsp_data_q};
    assign bus.busy_o      = busy_q;
    assign bus.txn_count_o = txn_q;
endmodule

// File: tb/tb_hardware_ram_responder.sv
// Directed plus randomized bench for hardware_ram_responder against an array/queue reference model.
module tb_hardware_ram_responder;
    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned LATENCY = 2;
    localparam int unsigned DEPTH   = 1 << ADDR_W;

    logic clk;
    logic rstn;
    int   vectors;
    int   miscompares;
    int   txn_m;
    logic [63:0] mem_m [int];
    int   written_q[$];

    hardware_ram_responder_if bus ();

    hardware_ram_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
        .system1000      (clk),
        .system1000_rstn (rstn),
        .bus             (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [128:0] make_req(input logic wv, input logic [29:0] wa,
                                              input logic [63:0] wd, input logic rv,
                                              input logic [31:0] ra, input logic run);
        return {wv, wa, wd, rv, ra, run};
    endfunction

    // Waits for the response pulse, checking edge count from the current cycle and busy during it
    task automatic wait_resp(input string tag, input int exp_edges, output logic [63:0] data);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            n++;
            if (bus.ramstatus_o[64] === 1'b1) got = 1'b1;
        end
        check({tag, "_latency"}, got ? 128'(n) : 128'(-1), 128'(exp_edges));
        data = bus.ramstatus_o[63:0];
        if (got) check({tag, "_busy_in_resp"}, 128'(bus.busy_o), 128'd1);
    endtask

    // Ends a transaction: drop request, confirm the pulse was single-cycle and count moved
    task automatic close_txn(input string tag);
        bus.cpureq_i = '0;
        tick();
        check({tag, "_pulse_end"}, 128'(bus.ramstatus_o[64]), 128'd0);
        check({tag, "_busy_end"}, 128'(bus.busy_o), 128'd0);
        check({tag, "_count"}, 128'(bus.txn_count_o), 128'(txn_m));
    endtask

    task automatic do_write(input string tag, input logic [29:0] wa, input logic [63:0] wd);
        logic [63:0] d;
        bus.cpureq_i = make_req(1'b1, wa, wd, 1'b0, 32'd0, 1'b1);
        mem_m[int'(wa % DEPTH)] = wd;
        written_q.push_back(int'(wa % DEPTH));
        wait_resp(tag, LATENCY, d);
        check({tag, "_echo"}, 128'(d), 128'(wd));
        txn_m++;
        close_txn(tag);
    endtask

    task automatic do_read(input string tag, input logic [31:0] ra);
        logic [63:0] d;
        bus.cpureq_i = make_req(1'b0, 30'd0, 64'd0, 1'b1, ra, 1'b1);
        wait_resp(tag, LATENCY, d);
        check({tag, "_data"}, 128'(d), 128'(mem_m[int'(ra % DEPTH)]));
        txn_m++;
        close_txn(tag);
    endtask

    initial begin
        logic [63:0] d;
        vectors     = 0;
        miscompares = 0;
        txn_m       = 0;

        // Reset with random request traffic
        rstn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.cpureq_i = {$urandom, $urandom, $urandom, $urandom, 1'($urandom)};
            tick();
            check("rst_status", 128'(bus.ramstatus_o), 128'd0);
            check("rst_busy", 128'(bus.busy_o), 128'd0);
            check("rst_count", 128'(bus.txn_count_o), 128'd0);
        end
        bus.cpureq_i = '0;
        rstn = 1'b1;
        tick();
        check("post_rst_status", 128'(bus.ramstatus_o), 128'd0);
        check("post_rst_busy", 128'(bus.busy_o), 128'd0);
        check("post_rst_count", 128'(bus.txn_count_o), 128'd0);

        // Write then read back
        do_write("wr5", 30'd5, 64'hDEAD_BEEF_0123_4567);
        do_read("rd5", 32'd5);
        check("count_two", 128'(bus.txn_count_o), 128'd2);

        // Both valids: write wins, read follows on the next IDLE cycle
        bus.cpureq_i = make_req(1'b1, 30'd3, 64'h11, 1'b1, 32'd3, 1'b1);
        mem_m[3] = 64'h11;
        written_q.push_back(3);
        wait_resp("both_wr", LATENCY, d);
        check("both_wr_echo", 128'(d), 128'h11);
        txn_m++;
        bus.cpureq_i = make_req(1'b0, 30'd0, 64'd0, 1'b1, 32'd3, 1'b1);
        wait_resp("both_rd", LATENCY + 1, d);
        check("both_rd_data", 128'(d), 128'h11);
        txn_m++;
        close_txn("both");

        // Aliasing above ADDR_W
        do_write("alias_wr", 30'h405, 64'hAA);
        do_read("alias_rd", 32'h5);

        // Running flag low blocks acceptance
        bus.cpureq_i = make_req(1'b0, 30'd0, 64'd0, 1'b1, 32'd5, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("norun_busy", 128'(bus.busy_o), 128'd0);
            check("norun_valid", 128'(bus.ramstatus_o[64]), 128'd0);
        end
        bus.cpureq_i = make_req(1'b0, 30'd0, 64'd0, 1'b1, 32'd5, 1'b1);
        wait_resp("run_rd", LATENCY, d);
        check("run_rd_data", 128'(d), 128'(mem_m[5]));
        txn_m++;
        close_txn("run");

        // Reset while a read is in flight
        do_write("pre_rst_wr", 30'd7, {$urandom, $urandom});
        bus.cpureq_i = make_req(1'b0, 30'd0, 64'd0, 1'b1, 32'd7, 1'b1);
        tick();
        check("midrst_busy_before", 128'(bus.busy_o), 128'd1);
        rstn = 1'b0;
        bus.cpureq_i = '0;
        tick();
        txn_m = 0;
        check("midrst_status", 128'(bus.ramstatus_o), 128'd0);
        check("midrst_busy", 128'(bus.busy_o), 128'd0);
        check("midrst_count", 128'(bus.txn_count_o), 128'd0);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrst_no_pulse", 128'(bus.ramstatus_o[64]), 128'd0);
        end
        do_read("post_rst_rd", 32'd7);

        // Randomized mix with idle gaps where the running flag is low
        for (int i = 0; i < 30; i++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                bus.cpureq_i = {$urandom, $urandom, $urandom, $urandom, 1'b0};
                tick();
                check("rnd_gap_busy", 128'(bus.busy_o), 128'd0);
            end
            if (written_q.size() == 0 || $urandom_range(0, 1) == 1) begin
                do_write("rnd_wr", 30'($urandom), {$urandom, $urandom});
            end else begin
                int idx;
                idx = written_q[$urandom_range(0, written_q.size() - 1)];
                do_read("rnd_rd", {22'($urandom), 10'(idx)});
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
